// File: rtl/dm_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : dm_access_unit
// Description : Load/store access unit between a CPU request/response port and
//               a word-wide, combinationally-read data memory. Handles byte,
//               half and word accesses with alignment checking, sign/zero
//               extension of loads and read-modify-write for sub-word stores.
//
// Ports
//   clk, reset       : clock, synchronous active-high reset
//   req_valid/ready  : request handshake (ready only while idle)
//   req_we           : 1 = store, 0 = load
//   req_size         : 00 byte, 01 half, 10 word, 11 reserved (error)
//   req_sign         : sign-extend loads when 1
//   req_addr         : byte address
//   req_wdata        : right-aligned store data
//   resp_valid/ready : response handshake
//   resp_rdata       : extended load data (0 for stores and errors)
//   resp_err         : misaligned or reserved-size request
//   dm_addr          : word-aligned memory address (0 when not accessing)
//   dm_wd, dm_we     : memory write word and write enable
//   dm_rd            : memory read word, combinational from dm_addr
//
// Revision    : 1.0 - initial release
// ============================================================================
module dm_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wd,
    output logic        dm_we,
    input  logic [31:0] dm_rd
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_READ  = 2'd1;
    localparam logic [1:0] c_WRITE = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    localparam logic [1:0] c_SIZE_BYTE = 2'b00;
    localparam logic [1:0] c_SIZE_HALF = 2'b01;
    localparam logic [1:0] c_SIZE_WORD = 2'b10;
    localparam logic [1:0] c_SIZE_RSVD = 2'b11;

    logic [1:0]  r_state;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_sign;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_buf;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_req_err;
    logic [7:0]  w_lane_byte;
    logic [15:0] w_lane_half;
    logic [31:0] w_load;
    logic [31:0] w_merge;
    logic [31:0] w_word_addr;

    // Alignment/size check is done on the live request so the error path can
    // skip memory entirely and respond one cycle after acceptance.
    always_comb begin
        w_req_err = 1'b0;
        if (req_size == c_SIZE_RSVD)
            w_req_err = 1'b1;
        else if (req_size == c_SIZE_HALF && req_addr[0])
            w_req_err = 1'b1;
        else if (req_size == c_SIZE_WORD && req_addr[1:0] != 2'b00)
            w_req_err = 1'b1;
    end

    // Load extraction works directly on dm_rd in READ so the result is ready
    // to be registered at the same edge the buffer is captured.
    always_comb begin
        w_lane_byte = dm_rd[{r_addr[1:0], 3'b000} +: 8];
        w_lane_half = dm_rd[{r_addr[1], 4'b0000} +: 16];
        case (r_size)
            c_SIZE_BYTE: w_load = {{24{r_sign & w_lane_byte[7]}}, w_lane_byte};
            c_SIZE_HALF: w_load = {{16{r_sign & w_lane_half[15]}}, w_lane_half};
            default:     w_load = dm_rd;
        endcase
    end

    // Sub-word stores replace only the addressed lanes of the word read back
    // in READ; word stores write the store data unchanged.
    always_comb begin
        w_merge = r_buf;
        case (r_size)
            c_SIZE_BYTE: w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
            c_SIZE_HALF: w_merge[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
            default:     w_merge = r_wdata;
        endcase
    end

    assign w_word_addr = {r_addr[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_we    <= 1'b0;
            r_size  <= 2'b00;
            r_sign  <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_buf   <= 32'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_size  <= req_size;
                        r_sign  <= req_sign;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_rdata <= 32'd0;
                        r_err   <= w_req_err;
                        if (w_req_err)
                            r_state <= c_RESP;
                        else if (req_we && req_size == c_SIZE_WORD)
                            r_state <= c_WRITE;
                        else
                            r_state <= c_READ;
                    end
                end
                c_READ: begin
                    r_buf <= dm_rd;
                    if (r_we) begin
                        r_state <= c_WRITE;
                    end else begin
                        r_rdata <= w_load;
                        r_state <= c_RESP;
                    end
                end
                c_WRITE: begin
                    r_state <= c_RESP;
                end
                default: begin
                    // Returning to IDLE only; the next request is sampled on
                    // the following edge.
                    if (resp_ready)
                        r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (r_state == c_IDLE);
    assign resp_valid = (r_state == c_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

    assign dm_addr = (r_state == c_READ || r_state == c_WRITE) ? w_word_addr : 32'd0;
    assign dm_wd   = (r_state == c_WRITE) ? w_merge : 32'd0;
    // Gated by reset so a store caught in WRITE by a reset never reaches memory.
    assign dm_we   = (r_state == c_WRITE) && !reset;

endmodule
`default_nettype wire

// File: tb/tb_dm_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_access_unit
// Description : Self-checking bench for dm_access_unit with a behavioural
//               memory and an arithmetic reference model of load/store rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_access_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_sign;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] dm_addr;
    logic [31:0] dm_wd;
    logic        dm_we;
    logic [31:0] dm_rd;

    logic [31:0] mem     [0:63];
    logic [31:0] exp_mem [0:63];

    int checks = 0;
    int errors = 0;

    dm_access_unit u_dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_sign   (req_sign),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .dm_addr    (dm_addr),
        .dm_wd      (dm_wd),
        .dm_we      (dm_we),
        .dm_rd      (dm_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dm_rd = mem[dm_addr[7:2]];

    always @(posedge clk) begin
        if (dm_we)
            mem[dm_addr[7:2]] <= dm_wd;
    end

    task automatic set_word(input int idx, input logic [31:0] val);
        mem[idx]     = val;
        exp_mem[idx] = val;
    endtask

    // Reference model: derives the response straight from the access rules.
    task automatic model(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic er, output logic [31:0] rd, output int lat,
                         output int nwe, output logic [31:0] nw);
        int          nbits;
        int          sh;
        logic [63:0] m;
        logic [63:0] v;
        logic [31:0] old;
        old   = exp_mem[a[7:2]];
        er    = (sz == 2'd3) || ((a % (32'd1 << sz)) != 0);
        rd    = 32'd0;
        nw    = old;
        nwe   = 0;
        lat   = 1;
        if (!er) begin
            nbits = 8 * (1 << sz);
            sh    = 8 * int'(a % 4);
            m     = (64'd1 << nbits) - 64'd1;
            if (!we) begin
                v = ({32'd0, old} >> sh) & m;
                if (sg && v[nbits-1])
                    v = v | ~m;
                rd  = v[31:0];
                lat = 2;
            end else begin
                v   = ({32'd0, old} & ~(m << sh)) | (({32'd0, wd} & m) << sh);
                nw  = v[31:0];
                nwe = 1;
                lat = (sz == 2'd2) ? 2 : 3;
            end
        end
    endtask

    // Drives one request, scrambles request inputs while busy, holds
    // resp_ready low for `hold` response cycles, then completes the handshake.
    // ok drops if the unit was not ready at start, looked ready while busy,
    // or let the response change/write memory under backpressure.
    task automatic txn(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, input int hold,
                       output int lat, output logic [31:0] rd, output logic er,
                       output int nwe, output logic [31:0] wdw,
                       output logic [31:0] wadr, output logic ok);
        @(negedge clk);
        ok        = (req_ready === 1'b1);
        req_valid = 1'b1;
        req_we    = we;
        req_size  = sz;
        req_sign  = sg;
        req_addr  = a;
        req_wdata = wd;
        @(posedge clk);
        lat  = -1;
        nwe  = 0;
        wdw  = 32'd0;
        wadr = 32'd0;
        rd   = 32'hDEADBEEF;
        er   = 1'bx;
        for (int c = 1; c <= 20 && lat < 0; c++) begin
            @(negedge clk);
            req_valid = 1'($urandom);
            req_we    = 1'($urandom);
            req_size  = 2'($urandom);
            req_sign  = 1'($urandom);
            req_addr  = $urandom;
            req_wdata = $urandom;
            if (req_ready !== 1'b0) ok = 1'b0;
            if (dm_we === 1'b1) begin
                nwe++;
                wdw  = dm_wd;
                wadr = dm_addr;
            end
            if (resp_valid === 1'b1) begin
                lat = c;
                rd  = resp_rdata;
                er  = resp_err;
            end
        end
        if (lat >= 0) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                if (resp_valid !== 1'b1 || resp_rdata !== rd || resp_err !== er ||
                    req_ready !== 1'b0 || dm_we !== 1'b0)
                    ok = 1'b0;
            end
            resp_ready = 1'b1;
            @(posedge clk);
            #1;
        end
        resp_ready = 1'b0;
        req_valid  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'd0 ||
            resp_err !== 1'b0 || dm_addr !== 32'd0 || dm_wd !== 32'd0 || dm_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b vld=%b rd=%h err=%b da=%h wd=%h we=%b, want 1 0 0 0 0 0 0",
                     req_ready, resp_valid, resp_rdata, resp_err, dm_addr, dm_wd, dm_we);
        end
    endtask

    task automatic test_loads();
        int lat, nwe;
        logic [31:0] rd, wdw, wadr;
        logic er, ok;
        logic [31:0] exp_rd [4];
        logic [1:0]  szs    [4];
        logic        sgs    [4];
        logic [31:0] adrs   [4];
        exp_rd = '{32'h8899AABB, 32'hFFFFFF99, 32'h00000099, 32'hFFFF8899};
        szs    = '{2'd2, 2'd0, 2'd0, 2'd1};
        sgs    = '{1'b1, 1'b1, 1'b0, 1'b1};
        adrs   = '{32'h10, 32'h12, 32'h12, 32'h12};
        set_word(4, 32'h8899AABB);
        for (int i = 0; i < 4; i++) begin
            txn(1'b0, szs[i], sgs[i], adrs[i], $urandom, 0, lat, rd, er, nwe, wdw, wadr, ok);
            checks++;
            if (lat !== 2 || rd !== exp_rd[i] || er !== 1'b0 || nwe !== 0 || ok !== 1'b1) begin
                errors++;
                $display("FAIL load_%0d: got lat=%0d rd=%h err=%b we=%0d ok=%b, want lat=2 rd=%h err=0 we=0 ok=1",
                         i, lat, rd, er, nwe, ok, exp_rd[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat, nwe;
        logic [31:0] rd, wdw, wadr;
        logic er, ok;
        set_word(8, 32'h11223344);
        txn(1'b1, 2'd0, 1'b0, 32'h21, 32'hABCDEFAA, 0, lat, rd, er, nwe, wdw, wadr, ok);
        exp_mem[8] = 32'h1122AA44;
        checks++;
        if (lat !== 3 || nwe !== 1 || wdw !== 32'h1122AA44 || wadr !== 32'h20 ||
            rd !== 32'd0 || er !== 1'b0 || ok !== 1'b1) begin
            errors++;
            $display("FAIL sb_rmw: got lat=%0d we=%0d wd=%h wa=%h rd=%h err=%b ok=%b, want 3 1 1122aa44 20 0 0 1",
                     lat, nwe, wdw, wadr, rd, er, ok);
        end
        txn(1'b0, 2'd2, 1'b0, 32'h20, 32'd0, 0, lat, rd, er, nwe, wdw, wadr, ok);
        checks++;
        if (rd !== 32'h1122AA44 || lat !== 2 || er !== 1'b0 || ok !== 1'b1) begin
            errors++;
            $display("FAIL lw_after_sb: got rd=%h lat=%0d err=%b ok=%b, want 1122aa44 2 0 1", rd, lat, er, ok);
        end
    endtask

    task automatic test_misaligned();
        int lat, nwe;
        logic [31:0] rd, wdw, wadr;
        logic er, ok;
        set_word(8, 32'h55667788);
        set_word(4, 32'h8899AABB);
        txn(1'b1, 2'd2, 1'b0, 32'h22, 32'hCAFEF00D, 0, lat, rd, er, nwe, wdw, wadr, ok);
        checks++;
        if (lat !== 1 || er !== 1'b1 || rd !== 32'd0 || nwe !== 0 || ok !== 1'b1 ||
            mem[8] !== 32'h55667788) begin
            errors++;
            $display("FAIL misaligned_sw: got lat=%0d err=%b rd=%h we=%0d ok=%b mem=%h, want 1 1 0 0 1 55667788",
                     lat, er, rd, nwe, ok, mem[8]);
        end
        txn(1'b0, 2'd1, 1'b1, 32'h13, 32'd0, 0, lat, rd, er, nwe, wdw, wadr, ok);
        checks++;
        if (lat !== 1 || er !== 1'b1 || rd !== 32'd0 || nwe !== 0 || ok !== 1'b1 ||
            mem[4] !== 32'h8899AABB) begin
            errors++;
            $display("FAIL misaligned_lh: got lat=%0d err=%b rd=%h we=%0d ok=%b, want 1 1 0 0 1",
                     lat, er, rd, nwe, ok);
        end
        txn(1'b0, 2'd3, 1'b0, 32'h10, 32'd0, 0, lat, rd, er, nwe, wdw, wadr, ok);
        checks++;
        if (lat !== 1 || er !== 1'b1 || rd !== 32'd0 || nwe !== 0) begin
            errors++;
            $display("FAIL reserved_size: got lat=%0d err=%b rd=%h we=%0d, want 1 1 0 0", lat, er, rd, nwe);
        end
    endtask

    task automatic test_backpressure();
        int lat, nwe;
        logic [31:0] rd, wdw, wadr;
        logic er, ok;
        set_word(5, 32'h0BADC0DE);
        txn(1'b0, 2'd2, 1'b0, 32'h14, 32'd0, 4, lat, rd, er, nwe, wdw, wadr, ok);
        checks++;
        if (ok !== 1'b1 || rd !== 32'h0BADC0DE || lat !== 2 || er !== 1'b0) begin
            errors++;
            $display("FAIL backpressure: got ok=%b rd=%h lat=%0d err=%b, want 1 0badc0de 2 0", ok, rd, lat, er);
        end
    endtask

    task automatic test_reset_mid_store();
        logic seen_write;
        set_word(12, 32'hA5A55A5A);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'd1;
        req_sign  = 1'b0;
        req_addr  = 32'h30;
        req_wdata = 32'h0000BEEF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);             // READ
        @(negedge clk);             // WRITE
        seen_write = (dm_we === 1'b1) && (dm_addr === 32'h30);
        reset = 1'b1;
        #1;
        checks++;
        if (!seen_write || dm_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_write: got in_write=%b dm_we=%b, want in_write=1 dm_we=0", seen_write, dm_we);
        end
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem[12] !== 32'hA5A55A5A) begin
            errors++;
            $display("FAIL reset_drop: got rdy=%b vld=%b mem=%h, want 1 0 a5a55a5a", req_ready, resp_valid, mem[12]);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || mem[12] !== 32'hA5A55A5A) begin
            errors++;
            $display("FAIL reset_no_resp: got vld=%b mem=%h, want 0 a5a55a5a", resp_valid, mem[12]);
        end
    endtask

    task automatic test_random();
        int lat, nwe, e_lat, e_nwe, hold;
        logic [31:0] rd, wdw, wadr, e_rd, e_nw, a, wd;
        logic er, ok, e_er, we, sg;
        logic [1:0] sz;
        for (int i = 0; i < 60; i++) begin
            we   = 1'($urandom);
            sz   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            sg   = 1'($urandom);
            a    = 32'($urandom_range(0, 255));
            wd   = $urandom;
            hold = $urandom_range(0, 3);
            model(we, sz, sg, a, wd, e_er, e_rd, e_lat, e_nwe, e_nw);
            txn(we, sz, sg, a, wd, hold, lat, rd, er, nwe, wdw, wadr, ok);
            exp_mem[a[7:2]] = e_nw;
            checks++;
            if (lat !== e_lat || rd !== e_rd || er !== e_er || nwe !== e_nwe || ok !== 1'b1 ||
                (e_nwe == 1 && (wdw !== e_nw || wadr !== {a[31:2], 2'b00})) ||
                mem[a[7:2]] !== e_nw) begin
                errors++;
                $display("FAIL random_%0d we=%b sz=%0d sg=%b a=%h wd=%h: got lat=%0d rd=%h err=%b we=%0d wd=%h wa=%h ok=%b mem=%h, want lat=%0d rd=%h err=%b we=%0d mem=%h",
                         i, we, sz, sg, a, wd, lat, rd, er, nwe, wdw, wadr, ok, mem[a[7:2]],
                         e_lat, e_rd, e_er, e_nwe, e_nw);
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'd0;
        req_sign   = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        resp_ready = 1'b0;
        for (int i = 0; i < 64; i++) begin
            mem[i]     = $urandom;
            exp_mem[i] = mem[i];
        end

        test_reset();
        test_loads();
        test_back_to_back();
        test_misaligned();
        test_backpressure();
        test_reset_mid_store();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dm_access_unit.md
DM_ACCESS_UNIT -- requirements
Module: dm_access_unit

Interface
REQ-001 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high; sampled on rising edge of clk.
REQ-003 SHALL have port: req_valid  input  1  CPU request present.
REQ-004 SHALL have port: req_ready  output  1  unit can accept a request this cycle.
REQ-005 SHALL have port: req_we  input  1  1=store, 0=load.
REQ-006 SHALL have port: req_size  input  2  00=byte, 01=half, 10=word, 11=reserved.
REQ-007 SHALL have port: req_sign  input  1  load sign-extend when 1, zero-extend when 0.
REQ-008 SHALL have port: req_addr  input  32  byte address.
REQ-009 SHALL have port: req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 SHALL have port: resp_valid  output  1  response present.
REQ-011 SHALL have port: resp_ready  input  1  CPU accepts response.
REQ-012 SHALL have port: resp_rdata  output  32  load result, extended; 0 for stores and errors.
REQ-013 SHALL have port: resp_err  output  1  misaligned or reserved-size request.
REQ-014 SHALL have port: dm_addr  output  32  word-aligned address to data memory.
REQ-015 SHALL have port: dm_wd  output  32  write word to data memory.
REQ-016 SHALL have port: dm_we  output  1  data memory write enable, one cycle per store.
REQ-017 SHALL have port: dm_rd  input  32  data memory read word, combinational from dm_addr.

Function
REQ-018 SHALL implement states IDLE, READ, WRITE, RESP; req_ready=1 only in IDLE.
REQ-019 IDLE: on req_valid, SHALL latch we/size/sign/addr/wdata; error if size=11, size=01 with addr[0]=1, or size=10 with addr[1:0]!=0.
REQ-020 IDLE transitions: error -> RESP (err=1); word store -> WRITE; load or sub-word store -> READ; no req_valid -> IDLE.
REQ-021 READ (1 cycle): dm_addr={addr[31:2],2'b00}; SHALL capture dm_rd into word buffer; load -> RESP, sub-word store -> WRITE.
REQ-022 Load extract: byte = buffer[8*addr[1:0]+:8], half = buffer[16*addr[1]+:16], word = buffer; extended per latched sign into resp_rdata.
REQ-023 WRITE (1 cycle): dm_we=1, dm_addr=word address; dm_wd = wdata for word, else buffer with only the addressed byte/half lanes replaced by wdata[7:0]/[15:0]; -> RESP.
REQ-024 RESP: resp_valid=1, resp_rdata/resp_err held stable until resp_valid&&resp_ready, then -> IDLE; new request not accepted in same cycle.
REQ-025 Latency from accept edge to first resp_valid cycle: load 2, sw 2, sb/sh 3, error 1 cycle.
REQ-026 Outside READ/WRITE, dm_addr=0; outside WRITE, dm_wd=0 and dm_we=0.
REQ-027 Error requests SHALL never assert dm_we and never enter READ.
REQ-028 Request inputs SHALL be ignored in all states except IDLE.

Reset
REQ-029 Reset SHALL force state IDLE and clear latched request, buffer, resp_rdata, resp_err.
REQ-030 Reset values: req_ready=1 on the cycle after reset, resp_valid=0, resp_rdata=0, resp_err=0, dm_addr=0, dm_wd=0, dm_we=0.
REQ-031 dm_we SHALL be gated by !reset so a store in WRITE during a reset cycle does not write memory; in-flight transaction is dropped with no response.

Verification
REQ-032 Load word: DM[0x10]=0x8899AABB, lw addr 0x10 -> resp_valid 2 cycles after accept, rdata=0x8899AABB, err=0, dm_we never 1.
REQ-033 Signed/unsigned byte: DM[0x10]=0x8899AABB, lb addr 0x12 -> 0xFFFFFF99; lbu addr 0x12 -> 0x00000099; lh addr 0x12 -> 0xFFFF8899.
REQ-034 Store byte RMW: DM[0x20]=0x11223344, sb addr 0x21 wdata 0xABCDEFAA -> one dm_we pulse, dm_wd=0x1122AA44, resp 3 cycles after accept; subsequent lw 0x20 -> 0x1122AA44.
REQ-035 Misaligned: sw addr 0x22 and lh addr 0x13 -> resp_err=1 one cycle after accept, rdata=0, dm_we stays 0, memory unchanged.
REQ-036 Backpressure: lw with resp_ready=0 for 4 cycles -> resp_valid and rdata stable all 4 cycles, req_ready=0 until handshake completes.
REQ-037 Reset mid-store: assert reset in the WRITE cycle of sh addr 0x30 -> dm_we=0 that cycle, no response, DM[0x30] unchanged, req_ready=1 next cycle.
